// File: rtl/seq_stream_pkg.sv
// seq_stream_pkg: shared state encoding and default word width for seq_stream_ctrl.
`timescale 1ns/1ps
package seq_stream_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: streams words MSB first into an external 1010 Mealy detector and returns per-bit hit mask/count.
// Define SEQ_STREAM_TOTAL_EN to add the saturating total_hits running sum.
`timescale 1ns/1ps
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             det_en,
  output logic             det_x,
  input  logic             det_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     hit_mask,
  output logic [CNT_W-1:0] hit_cnt
`ifdef SEQ_STREAM_TOTAL_EN
  ,
  output logic [15:0]      total_hits
`endif
);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  state_t state_q, state_d;
  logic [W-1:0] shreg_q, shreg_d, mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        shreg_d = in_data;
        mask_d  = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end
      SHIFT: begin
        mask_d[LAST - idx_q] = det_z;
        cnt_d   = cnt_q + CNT_W'(det_z);
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == LAST) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = state_q == IDLE;
  assign det_en    = state_q == SHIFT;
  assign det_x     = det_en & shreg_q[W-1];
  assign out_valid = state_q == DONE;
  assign hit_mask  = mask_q;
  assign hit_cnt   = cnt_q;

`ifdef SEQ_STREAM_TOTAL_EN
  logic [15:0] total_q, total_d;
  logic [16:0] sum;

  always_comb begin
    sum     = {1'b0, total_q} + 17'(cnt_q);
    total_d = (out_valid && out_ready) ? (sum[16] ? 16'hFFFF : sum[15:0]) : total_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) total_q <= '0;
    else      total_q <= total_d;
  end

  assign total_hits = total_q;
`endif
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: scoreboard bench driving seq_stream_ctrl with a behavioural 1010 non-overlap Mealy detector.
`timescale 1ns/1ps
module tb_seq_stream_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [7:0] m;
    logic [3:0] c;
  } exp_t;

  logic clk = 0, rst = 0;
  logic in_valid = 0, out_ready = 0;
  logic [7:0] in_data = '0;
  logic in_ready, det_en, det_x, det_z, out_valid;
  logic [7:0] hit_mask;
  logic [3:0] hit_cnt;
`ifdef SEQ_STREAM_TOTAL_EN
  logic [15:0] total_hits;
`endif

  int checks = 0, errors = 0, cyc = 0, last_acc = 0;
  exp_t sb[$];
  logic [1:0] ds_q;

  seq_stream_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .det_en(det_en), .det_x(det_x), .det_z(det_z), .out_valid(out_valid),
    .out_ready(out_ready), .hit_mask(hit_mask), .hit_cnt(hit_cnt)
`ifdef SEQ_STREAM_TOTAL_EN
    , .total_hits(total_hits)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [1:0] dnext(input logic [1:0] s, input logic x);
    return x ? ((s == 2'd2) ? 2'd3 : 2'd1) : ((s == 2'd1) ? 2'd2 : 2'd0);
  endfunction

  assign det_z = det_en && !det_x && ds_q == 2'd3;
  always @(posedge clk or negedge rst)
    if (!rst) ds_q <= 2'd0;
    else if (det_en) ds_q <= dnext(ds_q, det_x);

  function automatic exp_t predict(input logic [1:0] s0, input logic [7:0] d);
    exp_t e;
    logic [1:0] s;
    s = s0;
    e.m = '0;
    e.c = '0;
    for (int i = 7; i >= 0; i--) begin
      e.m[i] = (s == 2'd3) && !d[i];
      e.c = e.c + 4'(e.m[i]);
      s = dnext(s, d[i]);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    in_valid = 1;
    in_data = d;
    @(posedge clk); #1;
    in_valid = 0;
    last_acc = cyc;
  endtask

  task automatic collect(input logic [7:0] d, input bit hold);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 30) begin
      if (n < W) begin
        chk("shift_det_en", 32'(det_en), 32'd1);
        chk("shift_det_x", 32'(det_x), 32'(d[W-1-n]));
      end
      @(posedge clk); #1; n++;
    end
    chk("latency", n, W);
    e = sb.pop_front();
    chk("hit_mask", 32'(hit_mask), 32'(e.m));
    chk("hit_cnt", 32'(hit_cnt), 32'(e.c));
    if (!hold) begin
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
    end
  endtask

  task automatic run_word(input logic [7:0] d, input logic [7:0] m, input logic [3:0] c);
    exp_t e;
    e.m = m;
    e.c = c;
    sb.push_back(e);
    accept(d);
    collect(d, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_det_en"}, 32'(det_en), 32'd0);
    chk({tag, "_det_x"}, 32'(det_x), 32'd0);
    chk({tag, "_hit_mask"}, 32'(hit_mask), 32'd0);
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("por");
    do_reset();
    run_word(8'b1010_1010, 8'b0001_0001, 4'd2);
    accept(8'b1111_0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #1;
    check_reset_outputs("mid_shift");
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check_reset_outputs("after_release");
  endtask

  task automatic test_patterns();
    run_word(8'b1010_1010, 8'b0001_0001, 4'd2);
    run_word(8'b1101_0000, 8'b0000_1000, 4'd1);
  endtask

  task automatic test_boundary();
    run_word(8'b0000_0101, 8'b0000_0000, 4'd0);
    run_word(8'b0000_0000, 8'b1000_0000, 4'd1);
  endtask

  task automatic test_backpressure();
    exp_t e;
    e.m = 8'b0001_0001;
    e.c = 4'd2;
    sb.push_back(e);
    accept(8'b1010_1010);
    collect(8'b1010_1010, 1);
    in_valid = 1;
    in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_det_en", 32'(det_en), 32'd0);
      chk("bp_hit_mask", 32'(hit_mask), 32'(e.m));
      chk("bp_hit_cnt", 32'(hit_cnt), 32'(e.c));
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_exit_in_ready", 32'(in_ready), 32'd1);
    chk("bp_exit_det_en", 32'(det_en), 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int prev;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 8'b0101_1010 : 8'($urandom);
      sb.push_back(predict(ds_q, d));
      prev = last_acc;
      accept(d);
      if (i > 0) chk("word_period", last_acc - prev, W + 2);
      collect(d, 0);
    end
  endtask

`ifdef SEQ_STREAM_TOTAL_EN
  task automatic test_total();
    do_reset();
    chk("total_reset", 32'(total_hits), 32'd0);
    run_word(8'b1010_1010, 8'b0001_0001, 4'd2);
    chk("total_after_1", 32'(total_hits), 32'd2);
    run_word(8'b1101_0000, 8'b0000_1000, 4'd1);
    run_word(8'b0000_1010, 8'b0000_0001, 4'd1);
    chk("total_after_3", 32'(total_hits), 32'd4);
  endtask
`endif

  initial begin
    test_reset();
    test_patterns();
    test_boundary();
    test_backpressure();
    test_back_to_back();
`ifdef SEQ_STREAM_TOTAL_EN
    test_total();
`endif
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
